// File: rtl/jt51_noise_mc.sv
// Multi-channel LFSR noise generator producing EG-scaled sign/magnitude words per channel.
// Optional per-channel restart strobe enabled with macro JT51_NOISE_RESTART_EN.
module jt51_noise_mc #(
    parameter int                CH     = 2,
    parameter int                LFSR_W = 17,
    parameter logic [LFSR_W-1:0] TAPS   = 17'h00009,
    parameter logic [LFSR_W-1:0] INIT   = 17'h0005A,
    parameter int                CNT_W  = 5,
    parameter int                EG_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic [CH-1:0]           ne,
    input  logic [CH*CNT_W-1:0]     nfrq,
    input  logic [CH*EG_W-1:0]      eg,
    input  logic [CH-1:0]           nrst,
    output logic [CH*(EG_W+1)-1:0]  out,
    output logic                    out_vld
);
    localparam int OW = EG_W + 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_vld <= 1'b0;
        else     out_vld <= cen;
    end

`ifndef JT51_NOISE_RESTART_EN
    logic unused_nrst;
    assign unused_nrst = ^nrst;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            localparam logic [LFSR_W-1:0] SEED = INIT ^ LFSR_W'(gi);

            logic [CNT_W-1:0]  cnt_reg;
            logic [LFSR_W-1:0] lfsr_reg;
            logic [OW-1:0]     out_reg;
            logic [CNT_W-1:0]  nfrq_c;
            logic [EG_W-1:0]   eg_c;
            logic              sign;
            logic              fb;
            logic [LFSR_W-1:0] lfsr_next;

            assign nfrq_c    = nfrq[gi*CNT_W +: CNT_W];
            assign eg_c      = eg[gi*EG_W +: EG_W];
            assign sign      = lfsr_reg[0];
            assign fb        = ^(lfsr_reg & TAPS);
            assign lfsr_next = {fb, lfsr_reg[LFSR_W-1:1]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg  <= '0;
                    lfsr_reg <= SEED;
                    out_reg  <= '0;
                end
`ifdef JT51_NOISE_RESTART_EN
                else if (nrst[gi]) begin
                    lfsr_reg <= SEED;
                    cnt_reg  <= nfrq_c;
                end
`endif
                else if (cen) begin
                    if (ne[gi]) begin
                        out_reg <= {sign, {EG_W{~sign}} ^ eg_c};
                        if (&cnt_reg) begin
                            cnt_reg  <= nfrq_c;
                            lfsr_reg <= lfsr_next;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= nfrq_c;
                        out_reg <= '0;
                    end
                    // An all-zero LFSR would never leave zero; reseed with 1 instead.
                    if (lfsr_reg == '0) lfsr_reg <= LFSR_W'(1);
                end
            end

            assign out[gi*OW +: OW] = out_reg;
        end
    endgenerate
endmodule
